// File: rtl/mem_bus_ctrl.sv
// Memory bus M-cycle sequencer: each accepted request runs T0..T3 with rd/wr strobes in T1-T2,
// optional T2 wait states bounded by WAIT_MAX, and a one-cycle completion pulse in T3.
module mem_bus_ctrl #(
  parameter int ADDR_SIZE = 16,
  parameter int DATA_SIZE = 8,
  parameter int WAIT_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_wr,
  input  logic                 req_fetch,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 bus_err,
  output logic [ADDR_SIZE-1:0] addr_bus,
  output logic [DATA_SIZE-1:0] data_out,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 rd,
  output logic                 wr,
  input  logic                 mem_wait,
  output logic [1:0]           t_cycle,
  output logic                 m1t1
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic [DATA_SIZE-1:0] rdata_q, rdata_d;
  logic                 wr_q, wr_d;
  logic                 fetch_q, fetch_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      fetch_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      fetch_q <= fetch_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    fetch_d   = fetch_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cnt_inc   = cnt_q + 1'b1;
    req_ready = (state_q == IDLE) || (state_q == T3);
    accept    = req_valid && req_ready;

    case (state_q)
      IDLE, T3: begin
        err_d   = 1'b0;
        state_d = IDLE;
        if (accept) begin
          state_d = T0;
          addr_d  = req_addr;
          wr_d    = req_wr;
          // A fetch flag on a write is meaningless; treat it as a plain write.
          fetch_d = req_fetch && !req_wr;
          cnt_d   = '0;
          if (req_wr) dout_d = req_wdata;
        end
      end
      T0: state_d = T1;
      T1: state_d = T2;
      T2: begin
        if (mem_wait) begin
          if (cnt_inc == CNT_W'(WAIT_MAX)) begin
            state_d = T3;
            err_d   = 1'b1;
            if (!wr_q) rdata_d = '1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = T3;
          if (!wr_q) rdata_d = data_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      T1:      t_cycle = 2'd1;
      T2:      t_cycle = 2'd2;
      T3:      t_cycle = 2'd3;
      default: t_cycle = 2'd0;
    endcase
  end

  assign rd        = ((state_q == T1) || (state_q == T2)) && !wr_q;
  assign wr        = ((state_q == T1) || (state_q == T2)) && wr_q;
  assign m1t1      = (state_q == T0) && fetch_q;
  assign rsp_valid = (state_q == T3);
  assign bus_err   = (state_q == T3) && err_q;
  assign addr_bus  = addr_q;
  assign data_out  = dout_q;
  assign rsp_rdata = rdata_q;

endmodule
